// File: rtl/priority_encoder.sv
// Registered priority encoder: index, valid flag and one-hot grant of the
// winning request bit. The bit order that wins is selectable, and the output
// register can be bypassed for a purely combinational encoder.
module priority_encoder #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1,
    parameter bit          REG_OUT   = 1'b1,
    localparam int unsigned POS_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [POS_W-1:0] pos,
    output logic             valid,
    output logic [WIDTH-1:0] grant
);

    logic [POS_W-1:0] w_pos;
    logic             w_valid;
    logic [WIDTH-1:0] w_grant;

    // Encode: scan from the lowest-priority end so the winning bit is written last.
    always_comb begin
        w_pos   = '0;
        w_valid = |in;
        w_grant = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            int unsigned idx;
            idx = LSB_FIRST ? (WIDTH - 1 - k) : k;
            if (in[idx]) begin
                w_pos = POS_W'(idx);
            end
        end
        w_grant[w_pos] = w_valid;
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [POS_W-1:0] r_pos;
            logic             r_valid;
            logic [WIDTH-1:0] r_grant;

            // Output register: reset wins over capture, otherwise load every cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pos   <= '0;
                    r_valid <= 1'b0;
                    r_grant <= '0;
                end else begin
                    r_pos   <= w_pos;
                    r_valid <= w_valid;
                    r_grant <= w_grant;
                end
            end

            assign pos   = r_pos;
            assign valid = r_valid;
            assign grant = r_grant;
        end else begin : g_comb
            // Clock and reset have no function without the output register.
            logic w_unused;
            assign w_unused = clk ^ rst;

            assign pos   = w_pos;
            assign valid = w_valid;
            assign grant = w_grant;
        end
    endgenerate

endmodule

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;

    typedef struct {
        logic [1:0] l_pos;
        logic       l_valid;
        logic [3:0] l_grant;
        logic [1:0] m_pos;
        logic       m_valid;
        logic [3:0] m_grant;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in  = 4'b0000;
    logic [1:0] pos_l, pos_m;
    logic       valid_l, valid_m;
    logic [3:0] grant_l, grant_m;

    int tests_run    = 0;
    int tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    priority_encoder #(.WIDTH(4), .LSB_FIRST(1'b1), .REG_OUT(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in(in), .pos(pos_l), .valid(valid_l), .grant(grant_l)
    );

    priority_encoder #(.WIDTH(4), .LSB_FIRST(1'b0), .REG_OUT(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in(in), .pos(pos_m), .valid(valid_m), .grant(grant_m)
    );

    // Reference: search outward from the priority end, stop at the first set bit.
    function automatic exp_t model(input logic [3:0] v, input logic r);
        exp_t e;
        int   i;
        e = '{2'd0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        if (!r) begin
            i = 0;
            while (i < 4 && v[i] == 1'b0) i++;
            if (i < 4) begin
                e.l_pos = 2'(i); e.l_valid = 1'b1; e.l_grant = 4'(1 << i);
            end
            i = 3;
            while (i >= 0 && v[i] == 1'b0) i--;
            if (i >= 0) begin
                e.m_pos = 2'(i); e.m_valid = 1'b1; e.m_grant = 4'(1 << i);
            end
        end
        return e;
    endfunction

    // Apply one input on the falling edge and queue the result it should produce.
    task automatic drive(input logic [3:0] v, input logic r);
        @(negedge clk);
        in  = v;
        rst = r;
        sb.push_back(model(v, r));
    endtask

    // Wait for the capturing edge and hand back the matching expectation.
    task automatic collect(output exp_t e, output bit ok);
        @(posedge clk);
        #1;
        ok = (sb.size() != 0);
        if (ok) e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e; bit ok;
        for (int unsigned n = 0; n < 2; n++) begin
            drive(4'b1111, 1'b1);
            collect(e, ok);
            tests_run++;
            if (!ok || {pos_l, valid_l, grant_l, pos_m, valid_m, grant_m} !== 14'd0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: lsb pos=%0d valid=%b grant=%b msb pos=%0d valid=%b grant=%b, required all zero",
                         n, pos_l, valid_l, grant_l, pos_m, valid_m, grant_m);
            end
        end
    endtask

    task automatic test_single_bits();
        exp_t e; bit ok;
        for (int unsigned i = 0; i < 4; i++) begin
            logic [3:0] v;
            v = 4'(1 << i);
            drive(v, 1'b0);
            collect(e, ok);
            tests_run++;
            if (!ok || pos_l !== 2'(i) || valid_l !== 1'b1 || grant_l !== v ||
                pos_m !== 2'(i) || grant_m !== v) begin
                tests_failed++;
                $display("FAIL single_bit[%b]: pos=%0d/%0d valid=%b grant=%b/%b, required pos=%0d valid=1 grant=%b",
                         v, pos_l, pos_m, valid_l, grant_l, grant_m, i, v);
            end
        end
    endtask

    task automatic test_multi_bit();
        logic [3:0] vin [6] = '{4'b0110, 4'b1010, 4'b1111, 4'b1110, 4'b1001, 4'b1100};
        logic [1:0] vpos[6] = '{2'd1,    2'd1,    2'd0,    2'd1,    2'd0,    2'd2};
        exp_t e; bit ok;
        for (int unsigned i = 0; i < 6; i++) begin
            drive(vin[i], 1'b0);
            collect(e, ok);
            tests_run++;
            if (!ok || pos_l !== vpos[i] || valid_l !== 1'b1 || grant_l !== 4'(1 << vpos[i])) begin
                tests_failed++;
                $display("FAIL multi_bit[%b]: pos=%0d valid=%b grant=%b, required pos=%0d valid=1 grant=%b",
                         vin[i], pos_l, valid_l, grant_l, vpos[i], 4'(1 << vpos[i]));
            end
        end
    endtask

    task automatic test_zero_and_hold();
        logic [3:0] vin [3] = '{4'b1000, 4'b1000, 4'b0000};
        logic [1:0] vpos[3] = '{2'd3, 2'd3, 2'd0};
        logic       vval[3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] vgnt[3] = '{4'b1000, 4'b1000, 4'b0000};
        exp_t e; bit ok;
        for (int unsigned i = 0; i < 3; i++) begin
            drive(vin[i], 1'b0);
            collect(e, ok);
            tests_run++;
            if (!ok || pos_l !== vpos[i] || valid_l !== vval[i] || grant_l !== vgnt[i]) begin
                tests_failed++;
                $display("FAIL zero_hold[%0d]: pos=%0d valid=%b grant=%b, required pos=%0d valid=%b grant=%b",
                         i, pos_l, valid_l, grant_l, vpos[i], vval[i], vgnt[i]);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e; bit ok;
        for (int unsigned v = 0; v < 16; v++) begin
            drive(4'(v), 1'b0);
            collect(e, ok);
            tests_run++;
            if (!ok || pos_l !== e.l_pos || valid_l !== e.l_valid || grant_l !== e.l_grant ||
                pos_m !== e.m_pos || valid_m !== e.m_valid || grant_m !== e.m_grant) begin
                tests_failed++;
                $display("FAIL sweep[%b]: lsb %0d/%b/%b msb %0d/%b/%b, required lsb %0d/%b/%b msb %0d/%b/%b",
                         4'(v), pos_l, valid_l, grant_l, pos_m, valid_m, grant_m,
                         e.l_pos, e.l_valid, e.l_grant, e.m_pos, e.m_valid, e.m_grant);
            end
            if (v == 6 || v == 9) begin
                tests_run++;
                if (pos_m !== ((v == 6) ? 2'd2 : 2'd3)) begin
                    tests_failed++;
                    $display("FAIL msb_first[%b]: pos=%0d, required %0d",
                             4'(v), pos_m, (v == 6) ? 2 : 3);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       vrst[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e; bit ok;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(4'b0100, vrst[i]);
            collect(e, ok);
            tests_run++;
            if (vrst[i]) begin
                if (!ok || {pos_l, valid_l, grant_l, pos_m, valid_m, grant_m} !== 14'd0) begin
                    tests_failed++;
                    $display("FAIL mid_reset[%0d]: lsb %0d/%b/%b msb %0d/%b/%b, required all zero",
                             i, pos_l, valid_l, grant_l, pos_m, valid_m, grant_m);
                end
            end else if (!ok || pos_l !== 2'd2 || valid_l !== 1'b1 || grant_l !== 4'b0100 ||
                         pos_m !== 2'd2 || valid_m !== 1'b1) begin
                tests_failed++;
                $display("FAIL mid_reset[%0d]: pos=%0d/%0d valid=%b/%b grant=%b, required pos=2 valid=1 grant=0100",
                         i, pos_l, pos_m, valid_l, valid_m, grant_l);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_bits();
        test_multi_bit();
        test_zero_and_hold();
        test_sweep();
        test_mid_reset();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
